if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage for the pipelined two-bit-prediction core. Owns the PC and drives the combinational instruction memory address. Predicts next PC with a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB). Registers the fetched instruction into the IF/ID pipeline register consumed by decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BHT_ENTRIES, 64, counter/BTB entries; power of two, >= 2.
IDX_W, $clog2(BHT_ENTRIES), index width (derived, not overridden).

Ports:
clk_i  in  1  single clock, rising edge.
rst_i  in  1  synchronous, active-high reset.
stall_i  in  1  hazard unit: hold PC and IF/ID.
redirect_i  in  1  EX mispredict or jump correction.
redirect_pc_i  in  32  corrected fetch PC.
upd_en_i  in  1  EX resolved a branch/jump this cycle.
upd_pc_i  in  32  PC of the resolved branch.
upd_taken_i  in  1  actual outcome.
upd_target_i  in  32  actual target.
imem_addr_o  out  32  byte address to instruction memory (equals PC).
imem_data_i  in  32  instruction word, combinational, same cycle.
id_valid_o  out  1  IF/ID holds a real instruction.
id_pc_o  out  32  PC of the IF/ID instruction.
id_instr_o  out  32  instruction word.
id_pred_taken_o  out  1  prediction made for this instruction.
id_pred_target_o  out  32  predicted next PC (pc+4 if not taken).

Behaviour:
- Reset (rst_i=1 at clk edge): pc<=RESET_PC; id_valid_o=0, id_instr_o=32'h0000_0013 (NOP), id_pc_o=0, id_pred_taken_o=0, id_pred_target_o=0; all counters<=WNT (2'b01); all BTB valid<=0. Reset overrides every other input, including mid-redirect or mid-stall.
- imem_addr_o = pc, combinational; no memory latency; instruction available the same cycle.
- Lookup: idx=pc[IDX_W+1:2], tag=pc[31:IDX_W+2]. hit=btb_valid[idx] && btb_tag[idx]==tag. pred_taken=hit && counter[idx][1]. pred_next = pred_taken ? btb_target[idx] : pc+4 (32-bit, wraps modulo 2^32).
- Next-PC priority at each edge: rst_i > redirect_i (pc<=redirect_pc_i) > stall_i (hold) > pred_next.
- IF/ID: redirect_i -> id_valid_o<=0, id_instr_o<=NOP, id_pred_taken_o<=0 (flush, overrides stall). Else stall_i -> hold all id_* outputs. Else capture {1, pc, imem_data_i, pred_taken, pred_next}.
- Update (upd_en_i, independent of stall/redirect): u=upd_pc_i[IDX_W+1:2]. Taken: counter saturating increment (ST stays ST). BTB[u] <= {valid=1, tag of upd_pc_i, upd_target_i}. Not taken: counter saturating decrement (SNT stays SNT); BTB unchanged.
- Lookup and update in the same cycle on the same index: lookup sees pre-update state; the write is visible from the next cycle.
- Counters are not tag-qualified (aliasing allowed); prediction requires a BTB hit.
- One update per cycle maximum; no internal hazard detection.

Decomposition:
- Package core_pkg (shared): NOP_INSTR=32'h0000_0013; enum bp_cnt_e {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11}; XLEN=32.
- Sub-module branch_predictor: counter array + BTB; combinational lookup port (pc -> pred_taken, pred_target), registered update port, synchronous reset. if_stage holds PC mux and IF/ID register.

Test Plan:
- Reset then free run, imem returns pc-derived words -> imem_addr_o 0,4,8,12; id_pc_o lags by one cycle; id_valid_o=1 from the 2nd edge; id_pred_taken_o=0.
- stall_i high 3 cycles at pc=0x10 -> imem_addr_o held 0x10; id_* frozen; fetch resumes at 0x14 after release.
- redirect_i with redirect_pc_i=0x200 while stall_i=1 -> next pc=0x200; id_valid_o=0, id_instr_o=0x00000013.
- Update pc=0x40 taken to 0x100 twice (WNT->WT->ST) -> next fetch of 0x40 gives id_pred_taken_o=1, id_pred_target_o=0x100, following PC 0x100. Three not-taken updates -> counter SNT; prediction 0x44.
- Aliasing: BTB entry from 0x40, fetch 0x40+4*BHT_ENTRIES -> tag miss, predict pc+4. Same-cycle update and lookup of 0x40 -> old prediction used this cycle, new one next cycle.
- Assert rst_i during a predicted-taken stream -> pc=RESET_PC next edge; BTB cleared, so a re-fetch of 0x40 predicts 0x44.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipelined two-bit-prediction core.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Two-bit saturating branch counter states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped two-bit counter table plus branch target buffer.
// The lookup path is combinational. Updates take effect at the next clock edge,
// so a lookup and an update to the same index in one cycle see the old state.
module branch_predictor
    import core_pkg::*;
#(
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    bp_cnt_e              cnt        [BHT_ENTRIES];
    logic                 btb_valid  [BHT_ENTRIES];
    logic [TAG_W-1:0]     btb_tag    [BHT_ENTRIES];
    logic [XLEN-1:0]      btb_target [BHT_ENTRIES];

    logic [IDX_W-1:0]     look_idx;
    logic [TAG_W-1:0]     look_tag;
    logic                 look_hit;
    logic [IDX_W-1:0]     upd_idx;
    logic [TAG_W-1:0]     upd_tag;

    function automatic bp_cnt_e sat_inc(input bp_cnt_e c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic bp_cnt_e sat_dec(input bp_cnt_e c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

    assign look_idx = lookup_pc[IDX_W+1:2];
    assign look_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[XLEN-1:IDX_W+2];

    // Lookup: predict taken only on a BTB hit whose counter leans taken.
    always_comb begin
        look_hit    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
        pred_taken  = look_hit && cnt[look_idx][1];
        pred_target = pred_taken ? btb_target[look_idx] : lookup_pc + 32'd4;
    end

    // Control state: counters and BTB valid bits, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt[i]       <= WNT;
                btb_valid[i] <= 1'b0;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                cnt[upd_idx]       <= sat_inc(cnt[upd_idx]);
                btb_valid[upd_idx] <= 1'b1;
            end else begin
                cnt[upd_idx]       <= sat_dec(cnt[upd_idx]);
            end
        end
    end

    // BTB payload: tag and target are only meaningful under a valid bit.
    always_ff @(posedge clk_i) begin
        if (upd_en && upd_taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address, consults the branch predictor and fills the IF/ID register.
module if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        upd_en_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_pred_taken_o,
    output logic [31:0] id_pred_target_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0] pc_p0;
    logic            pred_taken_p0;
    logic [XLEN-1:0] pred_next_p0;

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] instr_p1;
    logic            pred_taken_p1;
    logic [XLEN-1:0] pred_target_p1;

    branch_predictor #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lookup_pc   (pc_p0),
        .pred_taken  (pred_taken_p0),
        .pred_target (pred_next_p0),
        .upd_en      (upd_en_i),
        .upd_pc      (upd_pc_i),
        .upd_taken   (upd_taken_i),
        .upd_target  (upd_target_i)
    );

    assign imem_addr_o = pc_p0;

    // PC register: reset, then redirect, then stall hold, else predicted next PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_p0 <= RESET_PC;
        end else if (redirect_i) begin
            pc_p0 <= redirect_pc_i;
        end else if (!stall_i) begin
            pc_p0 <= pred_next_p0;
        end
    end

    // ---- IF / ID boundary ----
    // IF/ID register: a redirect flushes even while stalled; a stall freezes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1         <= 1'b0;
            pc_p1          <= '0;
            instr_p1       <= NOP_INSTR;
            pred_taken_p1  <= 1'b0;
            pred_target_p1 <= '0;
        end else if (redirect_i) begin
            vld_p1         <= 1'b0;
            instr_p1       <= NOP_INSTR;
            pred_taken_p1  <= 1'b0;
        end else if (!stall_i) begin
            vld_p1         <= 1'b1;
            pc_p1          <= pc_p0;
            instr_p1       <= imem_data_i;
            pred_taken_p1  <= pred_taken_p0;
            pred_target_p1 <= pred_next_p0;
        end
    end

    assign id_valid_o       = vld_p1;
    assign id_pc_o          = pc_p1;
    assign id_instr_o       = instr_p1;
    assign id_pred_taken_o  = pred_taken_p1;
    assign id_pred_target_o = pred_target_p1;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: free-run fetch, stall, redirect, predictor
// training, aliasing, same-cycle update/lookup, PC wrap and mid-stream reset.
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        upd_en_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_pred_taken_o;
    logic [31:0] id_pred_target_o;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage #(
        .RESET_PC    (32'h0000_0000),
        .BHT_ENTRIES (64)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .upd_en_i         (upd_en_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .imem_addr_o      (imem_addr_o),
        .imem_data_i      (imem_data_i),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_instr_o       (id_instr_o),
        .id_pred_taken_o  (id_pred_taken_o),
        .id_pred_target_o (id_pred_target_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory returns an address-derived word.
    assign imem_data_i = imem_addr_o ^ 32'hDEAD_0000;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        step();
        redirect_i    = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        upd_en_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
        step();
        step();
        chk("rst_pc",       imem_addr_o, 32'h0);
        chk("rst_valid",    {31'b0, id_valid_o}, 32'h0);
        chk("rst_instr",    id_instr_o, NOP);
        chk("rst_idpc",     id_pc_o, 32'h0);
        chk("rst_ptaken",   {31'b0, id_pred_taken_o}, 32'h0);
        chk("rst_ptarget",  id_pred_target_o, 32'h0);

        // Free run
        rst_i = 1'b0;
        step();
        chk("run1_pc",      imem_addr_o, 32'h4);
        chk("run1_valid",   {31'b0, id_valid_o}, 32'h1);
        chk("run1_idpc",    id_pc_o, 32'h0);
        chk("run1_instr",   id_instr_o, 32'hDEAD_0000);
        chk("run1_ptarget", id_pred_target_o, 32'h4);
        step();
        chk("run2_pc",      imem_addr_o, 32'h8);
        chk("run2_idpc",    id_pc_o, 32'h4);
        step();
        chk("run3_pc",      imem_addr_o, 32'hC);
        step();
        chk("run4_pc",      imem_addr_o, 32'h10);
        chk("run4_idpc",    id_pc_o, 32'hC);
        chk("run4_ptaken",  {31'b0, id_pred_taken_o}, 32'h0);

        // Stall three cycles at 0x10
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    imem_addr_o, 32'h10);
            chk("stall_idpc",  id_pc_o, 32'hC);
            chk("stall_instr", id_instr_o, 32'hDEAD_000C);
        end
        stall_i = 1'b0;
        step();
        chk("resume_pc",    imem_addr_o, 32'h14);
        chk("resume_idpc",  id_pc_o, 32'h10);

        // Redirect while stalled
        stall_i = 1'b1;
        redirect_to(32'h200);
        stall_i = 1'b0;
        chk("redir_pc",     imem_addr_o, 32'h200);
        chk("redir_valid",  {31'b0, id_valid_o}, 32'h0);
        chk("redir_instr",  id_instr_o, NOP);
        chk("redir_ptaken", {31'b0, id_pred_taken_o}, 32'h0);

        // Train 0x40 taken to 0x100 twice: WNT -> WT -> ST
        upd_en_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h100;
        step();
        step();
        upd_en_i = 1'b0;
        chk("train_pc",     imem_addr_o, 32'h208);
        redirect_to(32'h40);
        step();
        chk("taken_idpc",   id_pc_o, 32'h40);
        chk("taken_ptaken", {31'b0, id_pred_taken_o}, 32'h1);
        chk("taken_target", id_pred_target_o, 32'h100);
        chk("taken_nextpc", imem_addr_o, 32'h100);

        // Three not-taken updates: ST -> WT -> WNT -> SNT
        upd_en_i = 1'b1; upd_taken_i = 1'b0;
        step();
        step();
        step();
        upd_en_i = 1'b0;
        redirect_to(32'h40);
        step();
        chk("snt_ptaken",   {31'b0, id_pred_taken_o}, 32'h0);
        chk("snt_target",   id_pred_target_o, 32'h44);
        chk("snt_nextpc",   imem_addr_o, 32'h44);

        // Retrain to WT, then fetch an alias with a different tag
        upd_en_i = 1'b1; upd_taken_i = 1'b1; upd_target_i = 32'h100;
        step();
        step();
        upd_en_i = 1'b0;
        redirect_to(32'h140);
        step();
        chk("alias_idpc",   id_pc_o, 32'h140);
        chk("alias_ptaken", {31'b0, id_pred_taken_o}, 32'h0);
        chk("alias_target", id_pred_target_o, 32'h144);

        // Same-cycle update (WT -> WNT) and lookup of 0x40
        redirect_to(32'h40);
        upd_en_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b0;
        step();
        upd_en_i = 1'b0;
        chk("same_ptaken",  {31'b0, id_pred_taken_o}, 32'h1);
        chk("same_target",  id_pred_target_o, 32'h100);
        chk("same_nextpc",  imem_addr_o, 32'h100);
        redirect_to(32'h40);
        step();
        chk("after_ptaken", {31'b0, id_pred_taken_o}, 32'h0);
        chk("after_target", id_pred_target_o, 32'h44);

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        step();
        chk("wrap_pc",      imem_addr_o, 32'h0);
        chk("wrap_target",  id_pred_target_o, 32'h0);

        // Retrain 0x40 taken (WNT -> WT -> ST), then reset mid taken stream
        upd_en_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h100;
        step();
        step();
        upd_en_i = 1'b0;
        redirect_to(32'h40);
        chk("pre_rst_pc",   imem_addr_o, 32'h40);
        rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300; stall_i = 1'b1;
        step();
        rst_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
        chk("mrst_pc",      imem_addr_o, 32'h0);
        chk("mrst_valid",   {31'b0, id_valid_o}, 32'h0);
        chk("mrst_instr",   id_instr_o, NOP);
        chk("mrst_ptarget", id_pred_target_o, 32'h0);
        redirect_to(32'h40);
        step();
        chk("post_ptaken",  {31'b0, id_pred_taken_o}, 32'h0);
        chk("post_target",  id_pred_target_o, 32'h44);
        chk("post_nextpc",  imem_addr_o, 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
